// File: rtl/expmod_cmd_parser.sv
// Frames a UART byte stream (header, value/exponent/modulus LSB first) into one command
// for exponent_modulus. Optional XOR checksum byte enabled by EXPMOD_CMD_CHECKSUM_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for HEADER, all other bytes ignored
// ST_PAYLOAD | collecting P payload bytes into the field registers
// ST_CHECK   | comparing the checksum byte against the XOR accumulator
// ST_HOLD    | command presented, waiting for cmd_ready_in; bytes dropped
module expmod_cmd_parser #(
   parameter int unsigned MSG_WIDTH      = 16,
   parameter int unsigned KEY_WIDTH      = 32,
   parameter logic [7:0]  HEADER         = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid_in,
   input  logic                 cmd_ready_in,
   output logic [MSG_WIDTH-1:0] value_out,
   output logic [KEY_WIDTH-1:0] exponent_out,
   output logic [KEY_WIDTH-1:0] modulus_out,
   output logic                 cmd_valid_out,
   output logic                 busy_out,
   output logic                 err_out,
   output logic                 overrun_out
);

   localparam int unsigned P     = MSG_WIDTH/8 + 2*(KEY_WIDTH/8);
   localparam int unsigned PW    = 8*P;
   localparam int unsigned IDX_W = $clog2(P);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P-1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES-1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [PW-1:0]     payload_q, payload_d;
   logic              err_q, err_d;
   logic              ovr_q, ovr_d;
`ifdef EXPMOD_CMD_CHECKSUM_EN
   logic [7:0]        acc_q, acc_d;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         payload_q <= '0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef EXPMOD_CMD_CHECKSUM_EN
         acc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         payload_q <= payload_d;
         err_q     <= err_d;
         ovr_q     <= ovr_d;
`ifdef EXPMOD_CMD_CHECKSUM_EN
         acc_q     <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      payload_d = payload_q;
      err_d     = 1'b0;
      ovr_d     = 1'b0;
      cnt_inc   = cnt_q + CNT_W'(1);
`ifdef EXPMOD_CMD_CHECKSUM_EN
      acc_d     = acc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (byte_valid_in && (byte_in == HEADER)) begin
               state_d = ST_PAYLOAD;
               idx_d   = '0;
`ifdef EXPMOD_CMD_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         ST_PAYLOAD: begin
            if (byte_valid_in) begin
               for (int unsigned i = 0; i < P; i++) begin
                  if (idx_q == IDX_W'(i)) payload_d[i*8 +: 8] = byte_in;
               end
`ifdef EXPMOD_CMD_CHECKSUM_EN
               acc_d = acc_q ^ byte_in;
`endif
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
`ifdef EXPMOD_CMD_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_HOLD;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (cnt_inc == CNT_LAST) begin
               // the counter reaching its last value is the timeout event itself
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`ifdef EXPMOD_CMD_CHECKSUM_EN
         ST_CHECK: begin
            if (byte_valid_in) begin
               cnt_d = '0;
               if (byte_in == acc_q) begin
                  state_d = ST_HOLD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (cnt_inc == CNT_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
`endif
         ST_HOLD: begin
            // includes the acceptance cycle: that byte is dropped, not parsed
            if (byte_valid_in) ovr_d = 1'b1;
            if (cmd_ready_in) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign value_out     = payload_q[MSG_WIDTH-1:0];
   assign exponent_out  = payload_q[MSG_WIDTH +: KEY_WIDTH];
   assign modulus_out   = payload_q[MSG_WIDTH+KEY_WIDTH +: KEY_WIDTH];
   assign cmd_valid_out = (state_q == ST_HOLD);
   assign busy_out      = (state_q != ST_IDLE);
   assign err_out       = err_q;
   assign overrun_out   = ovr_q;

endmodule

// File: tb/tb_expmod_cmd_parser.sv
// Directed bench for expmod_cmd_parser; follows EXPMOD_CMD_CHECKSUM_EN if defined.
module tb_expmod_cmd_parser;

   localparam int unsigned MW = 16;
   localparam int unsigned KW = 32;
   localparam int unsigned TO = 40;
   localparam int unsigned PB = MW/8 + 2*(KW/8);

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid_in = 1'b0;
   logic          cmd_ready_in = 1'b0;
   logic [MW-1:0] value_out;
   logic [KW-1:0] exponent_out;
   logic [KW-1:0] modulus_out;
   logic          cmd_valid_out;
   logic          busy_out;
   logic          err_out;
   logic          overrun_out;

   expmod_cmd_parser #(
      .MSG_WIDTH(MW), .KEY_WIDTH(KW), .HEADER(8'hA5), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
      .cmd_ready_in(cmd_ready_in), .value_out(value_out), .exponent_out(exponent_out),
      .modulus_out(modulus_out), .cmd_valid_out(cmd_valid_out), .busy_out(busy_out),
      .err_out(err_out), .overrun_out(overrun_out)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int err_cnt  = 0;
   int ovr_cnt  = 0;
   logic [7:0] last_cks;

   localparam logic [8*PB-1:0] NOM = {32'h00000CA1, 32'h00000011, 16'h0041};
   localparam logic [8*PB-1:0] AVL = {32'h00000CA1, 32'h00000011, 16'h00A5};

   always @(negedge clk_in) begin
      if (err_out) err_cnt++;
      if (overrun_out) ovr_cnt++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in       = b;
      byte_valid_in = 1'b1;
      tick();
      byte_valid_in = 1'b0;
      byte_in       = 8'h00;
   endtask

   task automatic send_frame(input logic [8*PB-1:0] pl, input logic [7:0] cks);
      last_cks = cks;
      send_byte(8'hA5);
      for (int i = 0; i < int'(PB); i++) send_byte(pl[i*8 +: 8]);
`ifdef EXPMOD_CMD_CHECKSUM_EN
      send_byte(last_cks);
`endif
   endtask

   task automatic run_frame(input string tag, input logic [8*PB-1:0] pl, input logic [7:0] cks,
                            input logic [15:0] ev, input logic [31:0] ee, input logic [31:0] em);
      int e0;
      e0 = err_cnt;
      cmd_ready_in = 1'b1;
      send_frame(pl, cks);
      check_eq({tag, "_valid"}, cmd_valid_out, 1);
      check_eq({tag, "_value"}, value_out, ev);
      check_eq({tag, "_exp"}, exponent_out, ee);
      check_eq({tag, "_mod"}, modulus_out, em);
      tick();
      check_eq({tag, "_valid_drop"}, cmd_valid_out, 0);
      check_eq({tag, "_busy_drop"}, busy_out, 0);
      check_eq({tag, "_no_err"}, err_cnt - e0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int o0;
      logic stable;

      rst_in = 1'b0;
      repeat (3) tick();
      check_eq("rst_valid", cmd_valid_out, 0);
      check_eq("rst_busy", busy_out, 0);
      check_eq("rst_fields", {value_out, exponent_out, modulus_out}, 0);
      check_eq("rst_pulses", {err_out, overrun_out}, 0);
      rst_in = 1'b1;
      tick();

      run_frame("nom", NOM, 8'hFD, 16'h0041, 32'h00000011, 32'h00000CA1);

`ifdef EXPMOD_CMD_CHECKSUM_EN
      e0 = err_cnt;
      send_frame(NOM, 8'hFC);
      check_eq("badck_err", err_out, 1);
      check_eq("badck_valid", cmd_valid_out, 0);
      check_eq("badck_busy", busy_out, 0);
      tick();
      check_eq("badck_err_once", err_cnt - e0, 1);
      check_eq("badck_valid2", cmd_valid_out, 0);
`endif

      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h12);
      check_eq("noise_busy", busy_out, 0);
      run_frame("noise_nom", NOM, 8'hFD, 16'h0041, 32'h00000011, 32'h00000CA1);
      run_frame("a5val", AVL, 8'h19, 16'h00A5, 32'h00000011, 32'h00000CA1);

      e0 = err_cnt;
      send_byte(8'hA5);
      check_eq("to_busy_hdr", busy_out, 1);
      send_byte(8'h41);
      send_byte(8'h00);
      send_byte(8'h11);
      for (int k = 1; k <= int'(TO) - 2; k++) tick();
      check_eq("to_err_early", err_out, 0);
      check_eq("to_busy_early", busy_out, 1);
      tick();
      check_eq("to_err", err_out, 1);
      check_eq("to_busy_fall", busy_out, 0);
      tick();
      check_eq("to_err_once", err_cnt - e0, 1);
      run_frame("to_nom", NOM, 8'hFD, 16'h0041, 32'h00000011, 32'h00000CA1);

      cmd_ready_in = 1'b0;
      send_frame(NOM, 8'hFD);
      check_eq("bp_valid", cmd_valid_out, 1);
      o0 = ovr_cnt;
      stable = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (c == 10 || c == 30) begin
            byte_in       = (c == 10) ? 8'hA5 : 8'h37;
            byte_valid_in = 1'b1;
         end
         tick();
         byte_valid_in = 1'b0;
         if (!(cmd_valid_out === 1'b1 && value_out === 16'h0041 &&
               exponent_out === 32'h00000011 && modulus_out === 32'h00000CA1))
            stable = 1'b0;
      end
      check_eq("bp_stable", stable, 1);
      check_eq("bp_overruns", ovr_cnt - o0, 2);
      cmd_ready_in  = 1'b1;
      byte_in       = 8'hA5;
      byte_valid_in = 1'b1;
      tick();
      byte_valid_in = 1'b0;
      check_eq("bp_accept_valid", cmd_valid_out, 0);
      check_eq("bp_accept_busy", busy_out, 0);
      check_eq("bp_accept_ovr", overrun_out, 1);
      tick();
      check_eq("bp_hdr_dropped", busy_out, 0);
      check_eq("bp_ovr_pulse", overrun_out, 0);
      check_eq("bp_retain", value_out, 16'h0041);

      send_byte(8'hA5);
      send_byte(8'h77);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h00);
      rst_in = 1'b0;
      #1;
      check_eq("mrst_valid_busy", {cmd_valid_out, busy_out}, 0);
      check_eq("mrst_fields", {value_out, exponent_out, modulus_out}, 0);
      check_eq("mrst_pulses", {err_out, overrun_out}, 0);
      tick();
      rst_in = 1'b1;
      tick();
      run_frame("mrst_nom", NOM, 8'hFD, 16'h0041, 32'h00000011, 32'h00000CA1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
